// File: rtl/demux_dest_fifo.sv
// demux_dest_fifo: routes each word to one of NUM_DEST FIFOs selected by dest_in; each FIFO is drained by its own pop.
// Optional macro DEMUX_DEST_DROPCNT_EN adds a saturating 8-bit drop_count output.
module demux_dest_fifo #(
    parameter int unsigned BITNUMBER   = 6,
    parameter int unsigned NUM_DEST    = 4,
    parameter int unsigned DEST_BITS   = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PTR_BITS    = 2,
    parameter int unsigned ALMOST_FULL = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BITNUMBER-1:0]          data_in,
    input  logic [DEST_BITS-1:0]          dest_in,
    input  logic                          valid_in,
    input  logic [NUM_DEST-1:0]           pop,
    output logic [NUM_DEST*BITNUMBER-1:0] data_out,
    output logic [NUM_DEST-1:0]           valid_out,
    output logic [NUM_DEST-1:0]           empty,
    output logic [NUM_DEST-1:0]           full,
    output logic [NUM_DEST-1:0]           almost_full,
    output logic                          pause
`ifdef DEMUX_DEST_DROPCNT_EN
    ,
    output logic [7:0]                    drop_count
`endif
);

    localparam int unsigned CNT_BITS = PTR_BITS + 1;
    localparam int unsigned DEST_W   = DEST_BITS + 1;

    logic                dest_ok_c;
    logic [NUM_DEST-1:0] push_c;

    assign dest_ok_c = ({1'b0, dest_in} < DEST_W'(NUM_DEST));

    for (genvar k = 0; k < NUM_DEST; k++) begin : g_dest
        logic [BITNUMBER-1:0] mem [FIFO_DEPTH];
        logic [PTR_BITS-1:0]  wr_ptr;
        logic [PTR_BITS-1:0]  rd_ptr;
        logic [CNT_BITS-1:0]  cnt;
        logic [BITNUMBER-1:0] dout;
        logic                 vout;
        logic                 pop_c;

        // A full FIFO refuses the push even when it is popped in the same cycle.
        assign push_c[k] = valid_in && dest_ok_c && (dest_in == DEST_BITS'(k))
                           && (cnt != CNT_BITS'(FIFO_DEPTH));
        assign pop_c     = pop[k] && (cnt != '0);

        // Storage needs no reset; contents are only read behind a non-zero count.
        always_ff @(posedge clk) begin
            if (push_c[k]) begin
                mem[wr_ptr] <= data_in;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                dout   <= '0;
                vout   <= 1'b0;
            end else begin
                if (push_c[k]) begin
                    wr_ptr <= wr_ptr + PTR_BITS'(1);
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PTR_BITS'(1);
                    dout   <= mem[rd_ptr];
                    vout   <= 1'b1;
                end else begin
                    dout   <= '0;
                    vout   <= 1'b0;
                end
                if (push_c[k] && !pop_c) begin
                    cnt <= cnt + CNT_BITS'(1);
                end else if (!push_c[k] && pop_c) begin
                    cnt <= cnt - CNT_BITS'(1);
                end
            end
        end

        assign data_out[k*BITNUMBER +: BITNUMBER] = dout;
        assign valid_out[k]   = vout;
        assign empty[k]       = (cnt == '0);
        assign full[k]        = (cnt == CNT_BITS'(FIFO_DEPTH));
        assign almost_full[k] = (cnt >= CNT_BITS'(ALMOST_FULL));
    end

    assign pause = |almost_full;

`ifdef DEMUX_DEST_DROPCNT_EN
    // Any valid word that no FIFO accepted was dropped.
    logic drop_c;
    assign drop_c = valid_in && (push_c == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop_c && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_dest_fifo.sv
// Directed bench for demux_dest_fifo: queue-based reference FIFOs plus a scoreboard of expected pop results.
// Build with DEMUX_DEST_DROPCNT_EN defined to also check drop_count.
module tb_demux_dest_fifo;

    localparam int BW = 6;
    localparam int ND = 4;
    localparam int DB = 3;
    localparam int FD = 4;
    localparam int AF = 3;

    typedef struct {
        logic [ND-1:0]    vo;
        logic [ND*BW-1:0] dout;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [BW-1:0]     data_in;
    logic [DB-1:0]     dest_in;
    logic              valid_in;
    logic [ND-1:0]     pop;
    logic [ND*BW-1:0]  data_out;
    logic [ND-1:0]     valid_out;
    logic [ND-1:0]     empty;
    logic [ND-1:0]     full;
    logic [ND-1:0]     almost_full;
    logic              pause;
`ifdef DEMUX_DEST_DROPCNT_EN
    logic [7:0]        drop_count;
`endif

    logic [BW-1:0] mq [ND][$];
    exp_t          sb [$];
    int            drops = 0;
    int            ncmp  = 0;
    int            nerr  = 0;

    demux_dest_fifo #(
        .BITNUMBER  (BW),
        .NUM_DEST   (ND),
        .DEST_BITS  (DB),
        .FIFO_DEPTH (FD),
        .PTR_BITS   (2),
        .ALMOST_FULL(AF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .dest_in    (dest_in),
        .valid_in   (valid_in),
        .pop        (pop),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .pause      (pause)
`ifdef DEMUX_DEST_DROPCNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        logic [ND-1:0] e_empty, e_full, e_af;
        for (int k = 0; k < ND; k++) begin
            e_empty[k] = (mq[k].size() == 0);
            e_full[k]  = (mq[k].size() == FD);
            e_af[k]    = (mq[k].size() >= AF);
        end
        chk("empty", 32'(empty), 32'(e_empty));
        chk("full", 32'(full), 32'(e_full));
        chk("almost_full", 32'(almost_full), 32'(e_af));
        chk("pause", 32'(pause), 32'(|e_af));
`ifdef DEMUX_DEST_DROPCNT_EN
        chk("drop_count", 32'(drop_count), 32'(drops));
`endif
    endtask

    task automatic chk_reset_vals();
        chk("rst_valid_out", 32'(valid_out), 32'h0);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_almost_full", 32'(almost_full), 32'h0);
        chk("rst_pause", 32'(pause), 32'h0);
`ifdef DEMUX_DEST_DROPCNT_EN
        chk("rst_drop_count", 32'(drop_count), 32'h0);
`endif
    endtask

    // One clock: update the reference model, queue the expected pop result, then compare after the edge.
    task automatic cycle(input logic v, input logic [DB-1:0] d, input logic [BW-1:0] w,
                         input logic [ND-1:0] p);
        exp_t e, got;
        logic [ND-1:0] full_pre;
        int di;
        di     = int'(d);
        e.vo   = '0;
        e.dout = '0;
        for (int k = 0; k < ND; k++) full_pre[k] = (mq[k].size() == FD);
        for (int k = 0; k < ND; k++) begin
            if (p[k] && mq[k].size() != 0) begin
                e.vo[k] = 1'b1;
                e.dout[k*BW +: BW] = mq[k].pop_front();
            end
        end
        if (v) begin
            if (di < ND && !full_pre[di]) mq[di].push_back(w);
            else if (drops < 255) drops++;
        end
        sb.push_back(e);
        valid_in = v;
        dest_in  = d;
        data_in  = w;
        pop      = p;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("valid_out", 32'(valid_out), 32'(got.vo));
        chk("data_out", 32'(data_out), 32'(got.dout));
        chk_status();
        valid_in = 1'b0;
        pop      = '0;
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        dest_in  = '0;
        data_in  = '0;
        pop      = '0;
        #12;
        chk_reset_vals();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single word to dest 2, popped next cycle.
        cycle(1'b1, 3'd2, 6'h15, 4'b0000);
        chk("t1_empty2", 32'(empty[2]), 32'h0);
        cycle(1'b0, 3'd0, 6'h00, 4'b0100);
        chk("t1_vo", 32'(valid_out), 32'h4);
        chk("t1_slice2", 32'(data_out[2*BW +: BW]), 32'h15);

        // Fill dest 1, overflow, drain in order.
        cycle(1'b1, 3'd1, 6'h01, 4'b0000);
        cycle(1'b1, 3'd1, 6'h02, 4'b0000);
        cycle(1'b1, 3'd1, 6'h03, 4'b0000);
        chk("t2_af1", 32'(almost_full[1]), 32'h1);
        chk("t2_full1_pre", 32'(full[1]), 32'h0);
        cycle(1'b1, 3'd1, 6'h04, 4'b0000);
        chk("t2_full1", 32'(full[1]), 32'h1);
        chk("t2_pause", 32'(pause), 32'h1);
        cycle(1'b1, 3'd1, 6'h05, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 3'd0, 6'h00, 4'b0010);
            chk("t2_order", 32'(data_out[1*BW +: BW]), 32'(i + 1));
        end
        chk("t2_empty1", 32'(empty[1]), 32'h1);

        // Full FIFO 0: simultaneous push and pop drops the push.
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd0, 6'(8'h20 + i), 4'b0000);
        cycle(1'b1, 3'd0, 6'h2A, 4'b0001);
        chk("t3_head", 32'(data_out[BW-1:0]), 32'h20);
        chk("t3_full0", 32'(full[0]), 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 6'h00, 4'b0001);

        // Steady push+pop on dest 3 with pointer wrap.
        cycle(1'b1, 3'd3, 6'h30, 4'b0000);
        cycle(1'b1, 3'd3, 6'h31, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 3'd3, 6'(8'h32 + i), 4'b1000);
            chk("t4_seq", 32'(data_out[3*BW +: BW]), 32'(8'h30 + i));
        end
        chk("t4_count2", 32'(int'(mq[3].size())), 32'd2);
        cycle(1'b0, 3'd0, 6'h00, 4'b1000);
        cycle(1'b0, 3'd0, 6'h00, 4'b1000);

        // Out-of-range destinations and pops on empties.
        cycle(1'b1, 3'd5, 6'h3F, 4'b0000);
        cycle(1'b1, 3'd4, 6'h3E, 4'b0000);
        cycle(1'b1, 3'd7, 6'h3D, 4'b0000);
        chk("t5_empty", 32'(empty), 32'hF);
        cycle(1'b0, 3'd0, 6'h00, 4'b1111);
        chk("t5_vo", 32'(valid_out), 32'h0);

        // Asynchronous reset with three FIFOs occupied and a pop in flight.
        cycle(1'b1, 3'd0, 6'h11, 4'b0000);
        cycle(1'b1, 3'd1, 6'h12, 4'b0000);
        cycle(1'b1, 3'd2, 6'h13, 4'b0000);
        cycle(1'b1, 3'd0, 6'h14, 4'b0000);
        cycle(1'b0, 3'd0, 6'h00, 4'b0001);
        chk("t6_pre_vo", 32'(valid_out), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals();
        for (int k = 0; k < ND; k++) mq[k].delete();
        drops = 0;
        #1;
        reset = 1'b1;
        cycle(1'b0, 3'd0, 6'h00, 4'b1111);
        chk("t6_after_vo", 32'(valid_out), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/demux_dest_fifo.md
# demux_dest_fifo

Parametrised 1-to-NUM_DEST destination demultiplexer with a per-destination FIFO and flow control. Successor to the two-way priority demux: the destination comes from an explicit index instead of per-channel valids, each output buffers FIFO_DEPTH words, and each output is drained by its own pop. It sits between the upstream arbiter/mux stage and the per-destination consumers. It raises `pause` so upstream can throttle before words are dropped.

## Interface
- BITNUMBER, 6, data word width
- NUM_DEST, 4, number of destinations (2..8)
- DEST_BITS, 2, width of dest_in; 2**DEST_BITS >= NUM_DEST
- FIFO_DEPTH, 4, words per destination FIFO; power of two, >= 2
- PTR_BITS, 2, log2(FIFO_DEPTH)
- ALMOST_FULL, 3, occupancy at or above which almost_full asserts (1..FIFO_DEPTH)

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- data_in  input  BITNUMBER  word to route
- dest_in  input  DEST_BITS  destination index for data_in
- valid_in  input  1  data_in/dest_in valid this cycle
- pop  input  NUM_DEST  per-destination read request
- data_out  output  NUM_DEST*BITNUMBER  packed outputs; destination k at [k*BITNUMBER +: BITNUMBER]
- valid_out  output  NUM_DEST  per-destination data_out valid
- empty  output  NUM_DEST  FIFO k holds 0 words
- full  output  NUM_DEST  FIFO k holds FIFO_DEPTH words
- almost_full  output  NUM_DEST  FIFO k occupancy >= ALMOST_FULL
- pause  output  1  OR of almost_full

## Operation
- Per destination: storage array, write pointer and read pointer (PTR_BITS, wrap modulo FIFO_DEPTH), and count (PTR_BITS+1 bits, 0..FIFO_DEPTH).
- Push: valid_in=1, dest_in<NUM_DEST, and full[dest_in]=0. data_in is written at wr_ptr, wr_ptr increments and count increments.
- Drop: valid_in=1 with dest_in>=NUM_DEST, or with full[dest_in]=1. The word is discarded and no state changes. Full blocks a push even if the same FIFO is popped that cycle.
- Pop k: pop[k]=1 and empty[k]=0. The head word is registered into data_out slice k, valid_out[k]<=1, rd_ptr increments and count decrements.
- No pop, or pop on empty: valid_out[k]<=0 and data_out slice k <=0. Pop on empty is ignored with no pointer change.
- Simultaneous push and pop on the same non-empty, non-full FIFO: both occur and count is unchanged.
- Push to one destination and pops on others in the same cycle are independent.
- Status outputs (empty/full/almost_full/pause) are combinational from count, so they reflect post-edge state.
- Reset values: data_out=0, valid_out=0, empty=all 1, full=0, almost_full=0, pause=0, all pointers and counts 0. Storage contents are don't-care.

## Timing
- Push at edge t: empty[k] deasserts after edge t.
- Earliest pop at cycle t+1: data_out/valid_out valid after edge t+1. Minimum valid_in-to-valid_out latency is 2 edges.
- valid_out[k] is a single-cycle pulse per pop. Back-to-back pops give one word per cycle in FIFO order.
- full/almost_full/pause update one edge after the push or pop causing them. Upstream must sample pause and stop within ALMOST_FULL..FIFO_DEPTH slack or accept drops.
- Reset low mid-transfer: all outputs take their reset values asynchronously. Queued words are lost. The first rising edge with reset high is a normal cycle.

## Configuration
- DEMUX_DEST_DROPCNT_EN defined: adds output drop_count (8 bits). It increments by 1 on every dropped word, saturates at 255 and resets to 0.
- Not defined: the drop_count port and counter are absent. Drop behaviour is identical.

## Test plan
- Reset, then push 0x15 to dest 2 and pop[2] next cycle -> valid_out=4'b0100 and data_out slice 2=0x15 two edges after the push. All other slices stay 0.
- Push 0x01..0x04 to dest 1 (FIFO_DEPTH=4) -> almost_full[1] after the 3rd push, full[1] and pause after the 4th. A 5th push of 0x05 is dropped (drop_count=1 if enabled). Four pops return 0x01..0x04 in order.
- Full FIFO 0 with push and pop[0] in the same cycle -> pop returns the head, the push is dropped and count goes to 3.
- FIFO 3 holding 2 words, push and pop on dest 3 each cycle for 8 cycles -> count stays 2, outputs appear in order and pointers wrap correctly.
- dest_in=5 with NUM_DEST=4, DEST_BITS=3 -> no FIFO changes and the word is dropped. pop on an empty FIFO -> valid_out stays 0.
- Assert reset low asynchronously between edges with 3 FIFOs non-empty -> all outputs are at reset values immediately. After release, pops return nothing.
